// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load
// write-back, with a registered write port and a pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int XLEN      = 64,
  parameter int NREG      = 32,
  parameter int AW        = 5,
  parameter int FIRST_PRI = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  input  logic            wb_stall,
  input  logic            claim_en,
  input  logic [AW-1:0]   claim_rd,
  output logic            rf_write_enable,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_wd,
  output logic [NREG-1:0] busy
);

  // 1 when the load port won the most recent accepted transfer
  logic            last_mem;
  logic            accept;
  logic            write_now;
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [NREG-1:0] busy_next;

  // Ready depends only on valids, stall and the pointer, never on ready itself
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (!wb_stall) begin
      if (alu_valid && (!mem_valid || last_mem)) begin
        alu_ready = 1'b1;
      end else if (mem_valid) begin
        mem_ready = 1'b1;
      end
    end
  end

  always_comb begin
    accept    = alu_ready | mem_ready;
    sel_rd    = alu_ready ? alu_rd : mem_rd;
    sel_data  = alu_ready ? alu_data : mem_data;
    write_now = accept && (sel_rd != '0);
  end

  // Clear on accept, then set on claim so a new producer wins a same-cycle clash
  always_comb begin
    busy_next = busy;
    if (write_now) begin
      busy_next[sel_rd] = 1'b0;
    end
    if (claim_en && (claim_rd != '0)) begin
      busy_next[claim_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_write_enable <= 1'b0;
      rf_rd           <= '0;
      rf_wd           <= '0;
      busy            <= '0;
      last_mem        <= (FIRST_PRI == 0);
    end else begin
      rf_write_enable <= write_now;
      if (write_now) begin
        rf_rd <= sel_rd;
        rf_wd <= sel_data;
      end
      if (accept) begin
        last_mem <= mem_ready;
      end
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration order, write latency,
// x0 suppression, stall, scoreboard and asynchronous reset.
module tb_regfile_wb_arbiter;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            alu_valid = 1'b0;
  logic [AW-1:0]   alu_rd = '0;
  logic [XLEN-1:0] alu_data = '0;
  logic            alu_ready;
  logic            mem_valid = 1'b0;
  logic [AW-1:0]   mem_rd = '0;
  logic [XLEN-1:0] mem_data = '0;
  logic            mem_ready;
  logic            wb_stall = 1'b0;
  logic            claim_en = 1'b0;
  logic [AW-1:0]   claim_rd = '0;
  logic            rf_write_enable;
  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_wd;
  logic [NREG-1:0] busy;

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .FIRST_PRI(0)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .wb_stall(wb_stall), .claim_en(claim_en), .claim_rd(claim_rd),
    .rf_write_enable(rf_write_enable), .rf_rd(rf_rd), .rf_wd(rf_wd), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [AW-1:0] ard, input logic [XLEN-1:0] ad,
                               input logic mv, input logic [AW-1:0] mrd, input logic [XLEN-1:0] md,
                               input logic st, input logic ce, input logic [AW-1:0] crd);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    wb_stall = st; claim_en = ce; claim_rd = crd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [AW-1:0] exp_rd [4];
    exp_rd[0] = 1; exp_rd[1] = 2; exp_rd[2] = 1; exp_rd[3] = 2;

    #12;
    checkOutput("reset_we", rf_write_enable, 0);
    checkOutput("reset_rd", rf_rd, 0);
    checkOutput("reset_wd", rf_wd, 0);
    checkOutput("reset_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // both valid from reset: ALU first, then alternate
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 64'h11, 1, 2, 64'h22, 0, 0, 0);
      checkOutput($sformatf("rr%0d_alu_ready", i), alu_ready, (i % 2 == 0));
      checkOutput($sformatf("rr%0d_mem_ready", i), mem_ready, (i % 2 == 1));
      tick();
      checkOutput($sformatf("rr%0d_we", i), rf_write_enable, 1);
      checkOutput($sformatf("rr%0d_rd", i), rf_rd, exp_rd[i]);
      checkOutput($sformatf("rr%0d_wd", i), rf_wd, (i % 2 == 0) ? 64'h11 : 64'h22);
    end
    idle();
    tick();
    checkOutput("rr_done_we", rf_write_enable, 0);

    // single ALU request
    applyStimulus(1, 5, 64'h1234, 0, 0, 0, 0, 0, 0);
    checkOutput("alu_only_ready", alu_ready, 1);
    checkOutput("alu_only_mem_ready", mem_ready, 0);
    tick();
    checkOutput("alu_only_we", rf_write_enable, 1);
    checkOutput("alu_only_rd", rf_rd, 5);
    checkOutput("alu_only_wd", rf_wd, 64'h1234);
    idle();
    tick();
    checkOutput("alu_only_we_drop", rf_write_enable, 0);
    checkOutput("alu_only_rd_hold", rf_rd, 5);

    // load to x0 is accepted but never written
    applyStimulus(0, 0, 0, 1, 0, 64'hFFFF, 0, 0, 0);
    checkOutput("x0_mem_ready", mem_ready, 1);
    tick();
    checkOutput("x0_we", rf_write_enable, 0);
    checkOutput("x0_rd_hold", rf_rd, 5);
    checkOutput("x0_wd_hold", rf_wd, 64'h1234);
    idle();

    // stall with both valid; last grant was MEM so ALU goes next
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 3, 64'h33, 1, 4, 64'h44, 1, 0, 0);
      checkOutput($sformatf("stall%0d_alu_ready", i), alu_ready, 0);
      checkOutput($sformatf("stall%0d_mem_ready", i), mem_ready, 0);
      tick();
      checkOutput($sformatf("stall%0d_we", i), rf_write_enable, 0);
    end
    applyStimulus(1, 3, 64'h33, 1, 4, 64'h44, 0, 0, 0);
    checkOutput("unstall_alu_ready", alu_ready, 1);
    checkOutput("unstall_mem_ready", mem_ready, 0);
    tick();
    checkOutput("unstall_rd", rf_rd, 3);
    idle();
    tick();

    // scoreboard
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 7);
    tick();
    checkOutput("claim7_busy", busy, 64'h80);
    applyStimulus(1, 7, 64'h77, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("wb7_busy", busy, 0);
    checkOutput("wb7_rd", rf_rd, 7);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 7);
    tick();
    checkOutput("reclaim7_busy", busy, 64'h80);
    applyStimulus(1, 7, 64'h78, 0, 0, 0, 0, 1, 7);
    tick();
    checkOutput("claim_and_wb7_busy", busy, 64'h80);
    applyStimulus(1, 7, 64'h79, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("clear7_busy", busy, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    checkOutput("claim0_busy", busy, 0);
    idle();

    // reset while a write is on the rf port
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 9);
    tick();
    checkOutput("claim9_busy", busy, 64'h200);
    applyStimulus(1, 6, 64'hABCD, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("pre_rst_we", rf_write_enable, 1);
    idle();
    rst = 1'b1;
    #1;
    checkOutput("rst_we", rf_write_enable, 0);
    checkOutput("rst_rd", rf_rd, 0);
    checkOutput("rst_wd", rf_wd, 0);
    checkOutput("rst_busy", busy, 0);
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkOutput("post_rst_we", rf_write_enable, 0);
    checkOutput("post_rst_rd", rf_rd, 0);
    applyStimulus(1, 1, 64'h5, 1, 2, 64'h6, 0, 0, 0);
    checkOutput("post_rst_alu_ready", alu_ready, 1);
    checkOutput("post_rst_mem_ready", mem_ready, 0);
    tick();
    checkOutput("post_rst_first_rd", rf_rd, 1);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Grants must be mutually exclusive at all times
  always @(negedge clk) begin
    if (!rst && alu_ready && mem_ready) begin
      bad++;
      $display("[TB] FAIL both_ready: got alu=1 mem=1 expected at most one");
    end
  end

endmodule
